// File: rtl/noc_pkg.sv
// Shared constants for the NoC fanout block and its helpers.
package noc_pkg;

  localparam int WIDTH_PACKAGE_DEFAULT = 33;
  localparam int NUM_OUT_MAX           = 16;
  localparam int COUNT_W_DEFAULT       = 16;

endpackage : noc_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Next count: clear wins, otherwise increment unless already saturated.
  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (inc && (value_q != {W{1'b1}})) begin
      value_d = value_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule : sat_counter

// File: rtl/noc_fanout.sv
// N-way packet replicator: one input packet is held until every port in its
// effective mask has taken a copy; each port handshakes independently.
module noc_fanout
  import noc_pkg::*;
#(
  parameter int WIDTH_PACKAGE = WIDTH_PACKAGE_DEFAULT,
  parameter int NUM_OUT       = 2,
  parameter int MULTICAST     = 1,
  parameter int COUNT_W       = COUNT_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH_PACKAGE-1:0] in_data,
  input  logic [NUM_OUT-1:0]       in_mask,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [WIDTH_PACKAGE-1:0] out_data,
  output logic                     busy,
  output logic [COUNT_W-1:0]       pkt_count,
  output logic [COUNT_W-1:0]       drop_count
);

  if (NUM_OUT < 2 || NUM_OUT > NUM_OUT_MAX) begin : g_bad_num_out
    $error("noc_fanout: NUM_OUT out of range");
  end

  logic [WIDTH_PACKAGE-1:0] data_q;
  logic [WIDTH_PACKAGE-1:0] data_d;
  logic [NUM_OUT-1:0]       pending_q;
  logic [NUM_OUT-1:0]       pending_d;
  logic [NUM_OUT-1:0]       pending_next;
  logic [NUM_OUT-1:0]       eff_mask;
  logic [NUM_OUT-1:0]       done;
  logic                     accept;
  logic                     pkt_inc;
  logic                     drop_inc;

  // Handshake bookkeeping; in_ready looks through this cycle's completions
  // so a new packet can load in the cycle the last copy leaves.
  always_comb begin
    eff_mask     = (MULTICAST != 0) ? in_mask : {NUM_OUT{1'b1}};
    done         = pending_q & out_ready;
    pending_next = pending_q & ~done;
    in_ready     = rst_n && (pending_next == '0);
    accept       = in_valid && in_ready;
  end

  // Load a new packet, drop an empty-mask one, or retire completed ports.
  always_comb begin
    data_d    = data_q;
    pending_d = pending_next;
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;
    if (accept) begin
      if (eff_mask != '0) begin
        data_d    = in_data;
        pending_d = eff_mask;
        pkt_inc   = 1'b1;
      end else begin
        drop_inc  = 1'b1;
      end
    end
  end

  // Packet holding register and per-port pending flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      pending_q <= '0;
    end else begin
      data_q    <= data_d;
      pending_q <= pending_d;
    end
  end

  sat_counter #(.W(COUNT_W)) u_pkt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .inc   (pkt_inc),
    .value (pkt_count)
  );

  sat_counter #(.W(COUNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .inc   (drop_inc),
    .value (drop_count)
  );

  assign out_valid = pending_q;
  assign out_data  = data_q;
  assign busy      = |pending_q;

endmodule : noc_fanout

// File: doc/noc_fanout.md
# noc_fanout

Clocked, parametrised N-way packet replicator for the NoC: it accepts one packet on a valid/ready input and delivers a copy to every selected output port. Each output completes its handshake independently, and a copy is never duplicated. It is the synchronous successor to the two-way CSP copy stage, with three additions: a configurable output count, per-packet multicast masks, and drop/packet counters. It sits between a router input stage and the per-destination output queues.

## Interface
- WIDTH_PACKAGE, 33, packet width in bits
- NUM_OUT, 2, number of output ports (2..16)
- MULTICAST, 1, 1 = honour in_mask; 0 = broadcast (in_mask ignored, treated as all ones)
- COUNT_W, 16, width of the status counters
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  input packet valid
- in_ready  output  1  input accept
- in_data  input  WIDTH_PACKAGE  packet
- in_mask  input  NUM_OUT  destination mask, sampled with in_data
- out_valid  output  NUM_OUT  per-port valid
- out_ready  input  NUM_OUT  per-port ready
- out_data  output  WIDTH_PACKAGE  shared data bus, same value on all ports
- busy  output  1  a packet is still pending on at least one port
- pkt_count  output  COUNT_W  packets accepted with a non-zero effective mask; saturating
- drop_count  output  COUNT_W  packets accepted with a zero effective mask; saturating

## Operation
- State:
  - data_q (WIDTH_PACKAGE)
  - pending_q (NUM_OUT): ports that have not yet taken the current packet
  - two counters
- Effective mask: eff_mask = MULTICAST ? in_mask : all ones.
- Output side:
  - out_valid = pending_q
  - out_data = data_q
  - done = out_valid & out_ready
  - pending_next = pending_q & ~done
- in_ready = rst_n && (pending_next == 0). This is a combinational path from out_ready, so a new packet loads in the same cycle the last pending port completes.
- Accept (in_valid && in_ready):
  - eff_mask != 0: data_q <= in_data, pending_q <= eff_mask, pkt_count += 1.
  - eff_mask == 0: the packet is dropped. pending_q stays 0, data_q is unchanged, drop_count += 1, and no output valid is raised.
- No accept: pending_q <= pending_next.
- A port that has completed must not see out_valid again for the same packet.
- A port's out_valid, once raised, stays high until its own handshake. It is independent of the other ports' out_ready.
- busy = |pending_q.
- Counters saturate at 2^COUNT_W-1 and do not wrap.
- Once a packet is loaded, out_data stays stable until every masked port has completed.

## Timing
- Reset (async assert, sync deassert expected externally):
  - pending_q = 0, data_q = 0, counters = 0
  - out_valid = 0, busy = 0
  - in_ready = 0 while rst_n is low, 1 in the first cycle after deassertion
- Latency: packet accepted at edge t gives out_valid at cycle t+1.
- Throughput: 1 packet/cycle when all masked ports are ready.
- Simultaneous events:
  - Last port completing and a new accept in the same cycle: the new packet loads, and out_valid for the new mask is asserted next cycle with no bubble.
  - Drop accepted while pending_q == 0: single-cycle, no output activity.
- Reset mid-operation: pending copies are discarded and no partial delivery completes afterwards. Counters clear.

## Structure
- Package noc_pkg holds:
  - the WIDTH_PACKAGE default constant (33)
  - the NUM_OUT upper bound (16)
  - the counter-width default
- The mask width is parameter-dependent and is declared locally.
- Sub-module sat_counter (parameter W; inputs inc and clear; output value) is instantiated twice, for pkt_count and drop_count.
- The fanout core (pending logic and handshake) lives in noc_fanout itself.

## Test plan
- Broadcast: NUM_OUT=3, MULTICAST=0, all out_ready=1, 8 back-to-back packets 0x0_0000_0001..8.
  - Each port sees all 8 in order, one per cycle, first out_valid one cycle after the first accept.
  - pkt_count=8.
- Stalled port: NUM_OUT=3, port 1 out_ready=0 for 5 cycles, then 1.
  - Ports 0 and 2 complete in cycle 1 and their out_valid drops.
  - in_ready=0 until port 1 completes, then the next packet loads in that same cycle.
- Multicast mask: in_mask=3'b101, data 0x1_2345_6789.
  - Only out_valid[0] and out_valid[2] assert; out_valid[1] stays 0.
  - in_ready returns once both complete.
- Zero mask: in_mask=0 with in_valid=1.
  - Accepted in one cycle, no out_valid, drop_count=1, pkt_count unchanged, data_q unchanged.
- Reset mid-packet: assert rst_n=0 while pending_q=3'b010.
  - out_valid=0 and in_ready=0 immediately; counters read 0.
  - After release, in_ready=1 and no stale copy appears.
- Saturation: COUNT_W=4, 20 drops.
  - drop_count holds at 15.
